// File: rtl/cu_fsm_if.sv
// Control-unit bus: instruction and branch flags in, datapath control out.
// The master modport is the control unit, the slave modport is the datapath side.
interface cu_fsm_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] ir;
  logic            br_eq;
  logic            br_lt;
  logic            br_ltu;
  logic            intr;
  logic            intr_en;

  logic            pc_we;
  logic [2:0]      pc_sel;
  logic            rf_we;
  logic [1:0]      rf_wr_sel;
  logic            mem_rden1;
  logic            mem_rden2;
  logic            mem_we2;
  logic [3:0]      alu_fun;
  logic            alu_srca;
  logic [1:0]      alu_srcb;
  logic            int_taken;
  logic            illegal;

  modport master (
    input  ir, br_eq, br_lt, br_ltu, intr, intr_en,
    output pc_we, pc_sel, rf_we, rf_wr_sel, mem_rden1, mem_rden2, mem_we2,
           alu_fun, alu_srca, alu_srcb, int_taken, illegal
  );

  modport slave (
    output ir, br_eq, br_lt, br_ltu, intr, intr_en,
    input  pc_we, pc_sel, rf_we, rf_wr_sel, mem_rden1, mem_rden2, mem_we2,
           alu_fun, alu_srca, alu_srcb, int_taken, illegal
  );
endinterface

// File: rtl/cu_fsm.sv
// Multicycle RV32I control unit: sequences fetch/exec/writeback/trap and decodes the
// instruction register into ALU, operand-select, PC, register-file and memory controls.
module cu_fsm #(
  parameter int unsigned XLEN = 32
) (
  input logic       clk,
  input logic       rst,
  cu_fsm_if.master  bus
);

  typedef enum logic [1:0] {StFetch, StExec, StWb, StTrap} state_e;

  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  state_e state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       trap_req;

  logic       pc_we;
  logic [2:0] pc_sel;
  logic       rf_we;
  logic [1:0] rf_wr_sel;
  logic       mem_rden1;
  logic       mem_rden2;
  logic       mem_we2;
  logic [3:0] alu_fun;
  logic       alu_srca;
  logic [1:0] alu_srcb;
  logic       int_taken;
  logic       illegal;

  logic       unused_ir;

  assign opcode    = bus.ir[6:0];
  assign funct3    = bus.ir[14:12];
  assign trap_req  = bus.intr & bus.intr_en;
  assign unused_ir = ^{bus.ir[XLEN-1:31], bus.ir[29:15], bus.ir[11:7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b0;
    pc_sel    = 3'd0;
    rf_we     = 1'b0;
    rf_wr_sel = 2'd0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    alu_fun   = 4'b0000;
    alu_srca  = 1'b0;
    alu_srcb  = 2'd0;
    int_taken = 1'b0;
    illegal   = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_rden1 = 1'b1;
        state_d   = StExec;
      end

      StExec: begin
        pc_we   = 1'b1;
        state_d = trap_req ? StTrap : StFetch;
        case (opcode)
          OpOp: begin
            alu_fun   = {bus.ir[30], funct3};
            rf_we     = 1'b1;
            rf_wr_sel = 2'd3;
          end
          OpOpImm: begin
            // Only the shift-right pair uses ir[30] to pick arithmetic vs logical.
            alu_fun   = {(funct3 == 3'b101) ? bus.ir[30] : 1'b0, funct3};
            alu_srcb  = 2'd1;
            rf_we     = 1'b1;
            rf_wr_sel = 2'd3;
          end
          OpLui: begin
            alu_fun   = 4'b1001;
            alu_srca  = 1'b1;
            rf_we     = 1'b1;
            rf_wr_sel = 2'd3;
          end
          OpAuipc: begin
            alu_srca  = 1'b1;
            alu_srcb  = 2'd3;
            rf_we     = 1'b1;
            rf_wr_sel = 2'd3;
          end
          OpJal: begin
            pc_sel = 3'd3;
            rf_we  = 1'b1;
          end
          OpJalr: begin
            pc_sel = 3'd1;
            rf_we  = 1'b1;
          end
          OpLoad: begin
            alu_srcb  = 2'd1;
            mem_rden2 = 1'b1;
            state_d   = StWb;
          end
          OpStore: begin
            alu_srcb = 2'd2;
            mem_we2  = 1'b1;
          end
          OpBranch: begin
            case (funct3)
              3'b000:  pc_sel = bus.br_eq  ? 3'd2 : 3'd0;
              3'b001:  pc_sel = !bus.br_eq ? 3'd2 : 3'd0;
              3'b100:  pc_sel = bus.br_lt  ? 3'd2 : 3'd0;
              3'b101:  pc_sel = !bus.br_lt ? 3'd2 : 3'd0;
              3'b110:  pc_sel = bus.br_ltu  ? 3'd2 : 3'd0;
              3'b111:  pc_sel = !bus.br_ltu ? 3'd2 : 3'd0;
              default: illegal = 1'b1;
            endcase
          end
          default: illegal = 1'b1;
        endcase
      end

      StWb: begin
        rf_we     = 1'b1;
        rf_wr_sel = 2'd2;
        state_d   = trap_req ? StTrap : StFetch;
      end

      StTrap: begin
        pc_we     = 1'b1;
        pc_sel    = 3'd4;
        int_taken = 1'b1;
        state_d   = StFetch;
      end

      default: state_d = StFetch;
    endcase

    // Reset cycle drops whatever instruction was in flight: no enables, no side effects.
    if (rst) begin
      pc_we     = 1'b0;
      pc_sel    = 3'd0;
      rf_we     = 1'b0;
      rf_wr_sel = 2'd0;
      mem_rden1 = 1'b0;
      mem_rden2 = 1'b0;
      mem_we2   = 1'b0;
      alu_fun   = 4'b0000;
      alu_srca  = 1'b0;
      alu_srcb  = 2'd0;
      int_taken = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign bus.pc_we     = pc_we;
  assign bus.pc_sel    = pc_sel;
  assign bus.rf_we     = rf_we;
  assign bus.rf_wr_sel = rf_wr_sel;
  assign bus.mem_rden1 = mem_rden1;
  assign bus.mem_rden2 = mem_rden2;
  assign bus.mem_we2   = mem_we2;
  assign bus.alu_fun   = alu_fun;
  assign bus.alu_srca  = alu_srca;
  assign bus.alu_srcb  = alu_srcb;
  assign bus.int_taken = int_taken;
  assign bus.illegal   = illegal;

endmodule

// File: tb/tb_cu_fsm.sv
// Bench for cu_fsm: directed instructions then random instruction streams with random
// interrupts, each compared cycle by cycle against a per-instruction transaction model.
module tb_cu_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cu_fsm_if #(.XLEN(32)) bus ();

  cu_fsm #(.XLEN(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%05h expected 0x%05h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Packed output bundle, field order fixed here for both expected and observed.
  function automatic logic [18:0] pk(input logic pc_we, input logic [2:0] pc_sel,
                                     input logic rf_we, input logic [1:0] wsel,
                                     input logic rd1, input logic rd2, input logic we2,
                                     input logic [3:0] alu, input logic srca,
                                     input logic [1:0] srcb, input logic it, input logic ill);
    return {pc_we, pc_sel, rf_we, wsel, rd1, rd2, we2, alu, srca, srcb, it, ill};
  endfunction

  function automatic logic [18:0] observed();
    return pk(bus.pc_we, bus.pc_sel, bus.rf_we, bus.rf_wr_sel, bus.mem_rden1, bus.mem_rden2,
              bus.mem_we2, bus.alu_fun, bus.alu_srca, bus.alu_srcb, bus.int_taken, bus.illegal);
  endfunction

  function automatic logic [18:0] exp_idle();
    return pk(0, 3'd0, 0, 2'd0, 0, 0, 0, 4'd0, 0, 2'd0, 0, 0);
  endfunction

  function automatic logic [18:0] exp_fetch();
    return pk(0, 3'd0, 0, 2'd0, 1, 0, 0, 4'd0, 0, 2'd0, 0, 0);
  endfunction

  function automatic logic [18:0] exp_wb();
    return pk(0, 3'd0, 1, 2'd2, 0, 0, 0, 4'd0, 0, 2'd0, 0, 0);
  endfunction

  function automatic logic [18:0] exp_trap();
    return pk(1, 3'd4, 0, 2'd0, 0, 0, 0, 4'd0, 0, 2'd0, 1, 0);
  endfunction

  function automatic bit is_load(input logic [31:0] ir);
    return ir[6:0] == 7'b0000011;
  endfunction

  // Execute-cycle controls straight from the instruction table.
  function automatic logic [18:0] exp_exec(input logic [31:0] ir, input logic eq,
                                           input logic lt, input logic ltu);
    logic [2:0] f3;
    logic [2:0] psel;
    logic       rfw;
    logic [1:0] ws;
    logic       rd2;
    logic       we2;
    logic [3:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic       ill;
    bit         taken;
    f3 = ir[14:12];
    psel = 3'd0; rfw = 0; ws = 2'd0; rd2 = 0; we2 = 0; alu = 4'd0; sa = 0; sb = 2'd0;
    ill = 0; taken = 0;
    case (ir[6:0])
      7'b0110011: begin alu = {ir[30], f3}; rfw = 1; ws = 2'd3; end
      7'b0010011: begin
        alu = {(f3 == 3'b101) ? ir[30] : 1'b0, f3}; sb = 2'd1; rfw = 1; ws = 2'd3;
      end
      7'b0110111: begin alu = 4'b1001; sa = 1; rfw = 1; ws = 2'd3; end
      7'b0010111: begin sa = 1; sb = 2'd3; rfw = 1; ws = 2'd3; end
      7'b1101111: begin psel = 3'd3; rfw = 1; end
      7'b1100111: begin psel = 3'd1; rfw = 1; end
      7'b0000011: begin sb = 2'd1; rd2 = 1; end
      7'b0100011: begin sb = 2'd2; we2 = 1; end
      7'b1100011: begin
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1;
        else begin
          case (f3[2:1])
            2'b00:   taken = eq;
            2'b10:   taken = lt;
            default: taken = ltu;
          endcase
          if (f3[0]) taken = !taken;
          psel = taken ? 3'd2 : 3'd0;
        end
      end
      default: ill = 1;
    endcase
    return pk(1, psel, rfw, ws, 0, rd2, we2, alu, sa, sb, 0, ill);
  endfunction

  task automatic step(input string tag, input logic [18:0] exp);
    @(negedge clk);
    check_eq(tag, {13'd0, observed()}, {13'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic drive_intr(input int pct);
    bus.intr    = ($urandom_range(0, 99) < pct);
    bus.intr_en = (pct >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  // One whole instruction: fetch, exec, optional writeback, optional trap.
  task automatic run_instr(input string tag, input logic [31:0] ir, input logic eq,
                           input logic lt, input logic ltu, input int pct);
    bit trap;
    bus.ir = ir; bus.br_eq = eq; bus.br_lt = lt; bus.br_ltu = ltu;
    drive_intr(pct);
    step({tag, "_fetch"}, exp_fetch());
    drive_intr(pct);
    trap = bus.intr && bus.intr_en;
    step({tag, "_exec"}, exp_exec(ir, eq, lt, ltu));
    if (is_load(ir)) begin
      drive_intr(pct);
      trap = bus.intr && bus.intr_en;
      step({tag, "_wb"}, exp_wb());
    end
    if (trap) begin
      drive_intr(pct);
      step({tag, "_trap"}, exp_trap());
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0] ops [9];
    logic [31:0] ir;
    logic [6:0] op;
    bit legal;
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011};
    ir = $urandom;
    if ($urandom_range(0, 9) == 0) begin
      do begin
        op = 7'($urandom);
        legal = 0;
        foreach (ops[i]) if (ops[i] == op) legal = 1;
      end while (legal);
    end else begin
      op = ops[$urandom_range(0, 8)];
    end
    ir[6:0] = op;
    return ir;
  endfunction

  initial begin
    logic [31:0] ir;
    bus.ir = 32'd0; bus.br_eq = 0; bus.br_lt = 0; bus.br_ltu = 0;
    bus.intr = 0; bus.intr_en = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset0", exp_idle());
    step("reset1", exp_idle());
    rst = 1'b0;

    run_instr("sub",   32'h40208033, 0, 0, 0, 0);
    run_instr("srai",  32'h4020D093, 0, 0, 0, 0);
    run_instr("xori",  32'h0020C093, 0, 0, 0, 0);
    run_instr("lw",    32'h0000A083, 0, 0, 0, 0);
    run_instr("beq_t", 32'h00208463, 1, 0, 0, 0);
    run_instr("beq_n", 32'h00208463, 0, 1, 1, 0);
    run_instr("b010",  32'h0020A463, 1, 1, 1, 0);
    run_instr("bad",   32'h0000007F, 0, 0, 0, 0);
    run_instr("lw_irq", 32'h0000A083, 0, 0, 0, 100);
    run_instr("add_irq", 32'h00208033, 0, 0, 0, 100);

    // Reset during exec of a store drops it and restarts at fetch.
    ir = 32'h0020A023;
    bus.ir = ir; bus.intr = 0; bus.intr_en = 0;
    step("sw_fetch", exp_fetch());
    rst = 1'b1;
    step("sw_rst_exec", exp_idle());
    rst = 1'b0;
    step("sw_refetch", exp_fetch());
    step("sw_exec", exp_exec(ir, 0, 0, 0));

    for (int n = 0; n < 400; n++) begin
      ir = rand_ir();
      run_instr("rnd", ir, 1'($urandom), 1'($urandom), 1'($urandom), 20);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        bus.intr = 0;
        step("rnd_rst", exp_idle());
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
